// File: rtl/sha_digest_serializer.sv
// Snapshots the 8x32-bit SHA-256 digest on a rising finish_flag and streams it
// over an 8-bit valid/ready port, as raw bytes or lowercase ASCII hex.
module sha_digest_serializer #(
  parameter int HEX_ASCII = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        finish_flag,
  input  logic [31:0] hash [8],
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [5:0] LAST_BEAT = (HEX_ASCII != 0) ? 6'd63 : 6'd31;

  state_t       state_q;
  logic         finish_flag_q;
  logic [255:0] snap_q;
  logic [5:0]   cnt_q;
  logic [5:0]   cnt_d;
  logic [7:0]   dout_q;
  logic         dout_valid_q;
  logic         dout_last_q;
  logic         busy_q;
  logic         done_q;
  logic         overrun_q;
  logic [255:0] hash_flat_s;
  logic         cap_req_s;
  logic         xfer_s;

  // Beat idx of a packed digest (word 0 in the top bits), raw byte or hex char.
  function automatic logic [7:0] beat_f(input logic [255:0] d, input logic [5:0] idx);
    logic [4:0]   k;
    logic [255:0] sh;
    logic [7:0]   b;
    logic [3:0]   nib;
    k   = (HEX_ASCII != 0) ? idx[5:1] : idx[4:0];
    sh  = d >> {5'd31 - k, 3'b000};
    b   = sh[7:0];
    nib = idx[0] ? b[3:0] : b[7:4];
    if (HEX_ASCII == 0) begin
      return b;
    end else if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

  always_comb begin
    hash_flat_s = {hash[0], hash[1], hash[2], hash[3], hash[4], hash[5], hash[6], hash[7]};
    cap_req_s   = finish_flag & ~finish_flag_q;
    xfer_s      = dout_valid_q & dout_ready;
    cnt_d       = cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      finish_flag_q <= 1'b1;
      snap_q        <= '0;
      cnt_q         <= 6'd0;
      dout_q        <= 8'h00;
      dout_valid_q  <= 1'b0;
      dout_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      finish_flag_q <= finish_flag;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cap_req_s) begin
            snap_q       <= hash_flat_s;
            cnt_q        <= 6'd0;
            dout_q       <= beat_f(hash_flat_s, 6'd0);
            dout_valid_q <= 1'b1;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (xfer_s && (cnt_q == LAST_BEAT)) begin
            done_q <= 1'b1;
            // A request landing on the final transfer chains straight into a new message.
            if (cap_req_s) begin
              snap_q      <= hash_flat_s;
              cnt_q       <= 6'd0;
              dout_q      <= beat_f(hash_flat_s, 6'd0);
              dout_last_q <= 1'b0;
            end else begin
              state_q      <= IDLE;
              dout_q       <= 8'h00;
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              busy_q       <= 1'b0;
            end
          end else begin
            if (xfer_s) begin
              cnt_q       <= cnt_d;
              dout_q      <= beat_f(snap_q, cnt_d);
              dout_last_q <= (cnt_d == LAST_BEAT);
            end
            if (cap_req_s) begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule
